// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_exec_unit_if : issue/writeback handshake bundle for the EX ALU |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            InValid;
  logic            InReady;
  logic [3:0]      AluSel;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            OutValid;
  logic            OutReady;
  logic [XLEN-1:0] Result;
  logic            Zero;

  modport master (
    output InValid, AluSel, A, B, OutReady,
    input  InReady, OutValid, Result, Zero
  );

  modport slave (
    input  InValid, AluSel, A, B, OutReady,
    output InReady, OutValid, Result, Zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_exec_unit : multi-cycle ALU, single-cycle logic/arith,        |
// | bit-serial shifts.  Revision 1.0                                  |
// +------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  wire logic        clk,
  input  wire logic        rst,
  alu_exec_unit_if.slave   bus
);
  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_XOR  = 4'b0011;
  localparam logic [3:0] c_ALU_SLL  = 4'b0100;
  localparam logic [3:0] c_ALU_SRL  = 4'b0101;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_SLT  = 4'b0111;
  localparam logic [3:0] c_ALU_SLTU = 4'b1000;
  localparam logic [3:0] c_ALU_SRA  = 4'b1001;
  localparam logic [3:0] c_ALU_PASS = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_op;
  logic [SHW-1:0]  r_count;
  logic [XLEN-1:0] r_result;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_shift;
  logic            w_is_shift;

  assign w_is_shift = (bus.AluSel == c_ALU_SLL) || (bus.AluSel == c_ALU_SRL) ||
                      (bus.AluSel == c_ALU_SRA);

  always_comb begin
    w_alu = bus.B;
    case (bus.AluSel)
      c_ALU_ADD:  w_alu = bus.A + bus.B;
      c_ALU_SUB:  w_alu = bus.A - bus.B;
      c_ALU_AND:  w_alu = bus.A & bus.B;
      c_ALU_OR:   w_alu = bus.A | bus.B;
      c_ALU_XOR:  w_alu = bus.A ^ bus.B;
      c_ALU_SLT:  w_alu = XLEN'($signed(bus.A) < $signed(bus.B));
      c_ALU_SLTU: w_alu = XLEN'(bus.A < bus.B);
      default:    w_alu = bus.B;
    endcase
  end

  // One-bit step of the serial shifter; r_op only holds a shift code while in S_SHIFT
  always_comb begin
    w_shift = r_result;
    case (r_op)
      c_ALU_SLL: w_shift = {r_result[XLEN-2:0], 1'b0};
      c_ALU_SRL: w_shift = {1'b0, r_result[XLEN-1:1]};
      default:   w_shift = {r_result[XLEN-1], r_result[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 4'd0;
      r_count     <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.InValid) begin
            r_op       <= bus.AluSel;
            r_in_ready <= 1'b0;
            if (w_is_shift) begin
              r_result <= bus.A;
              r_count  <= bus.B[SHW-1:0];
              if (bus.B[SHW-1:0] == '0) begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
              end else begin
                r_state <= S_SHIFT;
              end
            end else begin
              r_result    <= w_alu;
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_result <= w_shift;
          r_count  <= r_count - SHW'(1);
          if (r_count == SHW'(1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.OutReady) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InReady  = r_in_ready;
  assign bus.OutValid = r_out_valid;
  assign bus.Result   = r_result;
  assign bus.Zero     = (r_result == '0);
endmodule
`default_nettype wire
